// File: rtl/dm_sbus_arbiter.sv
// Round-robin arbiter sharing one system-bus master port between NumReq requesters.
// Define DM_SBUS_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
//   locked_q | meaning
//   0        | free: select by arbitration among current requests
//   1        | offered but ungranted: bus held for lock_idx_q
module dm_sbus_arbiter #(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned BusWidth       = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         dmactive_i,
  input  logic [NumReq-1:0]            req_i,
  input  logic [NumReq*BusWidth-1:0]   add_i,
  input  logic [NumReq-1:0]            we_i,
  input  logic [NumReq*BusWidth-1:0]   wdata_i,
  input  logic [NumReq*BusWidth/8-1:0] be_i,
  output logic [NumReq-1:0]            gnt_o,
  output logic [NumReq-1:0]            r_valid_o,
  output logic [BusWidth-1:0]          r_rdata_o,
  output logic                         master_req_o,
  output logic [BusWidth-1:0]          master_add_o,
  output logic                         master_we_o,
  output logic [BusWidth-1:0]          master_wdata_o,
  output logic [BusWidth/8-1:0]        master_be_o,
  input  logic                         master_gnt_i,
  input  logic                         master_r_valid_i,
  input  logic [BusWidth-1:0]          master_r_rdata_i,
  output logic                         resp_err_o
);
  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned BeW  = BusWidth / 8;
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);

  logic            locked_q;
  logic [IdxW-1:0] lock_idx_q;
  logic [IdxW-1:0] sel, cand;
  logic            found;
  logic            grant, push, pop;
  logic [IdxW-1:0] fifo_q [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;

`ifndef DM_SBUS_ARB_FIXED_PRIO_EN
  logic [IdxW-1:0] rr_ptr_q;

  function automatic logic [IdxW-1:0] wrap_idx(input logic [IdxW-1:0] base, input int unsigned off);
    int unsigned j;
    j = 32'(base) + off;
    if (j >= NumReq) j = j - NumReq;
    return IdxW'(j);
  endfunction
`endif

  always_comb begin
    sel   = lock_idx_q;
    cand  = '0;
    found = 1'b0;
    if (!locked_q) begin
      sel = '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
`ifdef DM_SBUS_ARB_FIXED_PRIO_EN
        cand = IdxW'(i);
`else
        cand = wrap_idx(rr_ptr_q, i);
`endif
        if (!found && req_i[cand]) begin
          sel   = cand;
          found = 1'b1;
        end
      end
    end
  end

  assign master_req_o = (locked_q | (|req_i)) & (cnt_q < MaxCnt) & dmactive_i;
  assign grant        = master_req_o & master_gnt_i;
  assign push         = grant;
  // A response with nothing outstanding is flagged rather than routed.
  assign pop          = master_r_valid_i & (cnt_q != '0);
  assign resp_err_o   = master_r_valid_i & (cnt_q == '0);

  assign master_add_o   = master_req_o ? add_i[sel*BusWidth +: BusWidth]   : '0;
  assign master_wdata_o = master_req_o ? wdata_i[sel*BusWidth +: BusWidth] : '0;
  assign master_be_o    = master_req_o ? be_i[sel*BeW +: BeW]              : '0;
  assign master_we_o    = master_req_o & we_i[sel];
  assign r_rdata_o      = pop ? master_r_rdata_i : '0;

  always_comb begin
    gnt_o = '0;
    if (grant) gnt_o[sel] = 1'b1;
  end

  always_comb begin
    r_valid_o = '0;
    if (pop) r_valid_o[fifo_q[rd_ptr_q]] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
    end else if (!dmactive_i) begin
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
    end else if (grant) begin
      locked_q   <= 1'b0;
    end else if (master_req_o) begin
      locked_q   <= 1'b1;
      lock_idx_q <= sel;
    end
  end

`ifndef DM_SBUS_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (!dmactive_i) begin
      rr_ptr_q <= '0;
    end else if (grant) begin
      rr_ptr_q <= (sel == LastIdx) ? '0 : sel + 1'b1;
    end
  end
`endif

  // In-order ID FIFO: the FIFO survives dmactive_i so in-flight responses still route.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < MaxOutstanding; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q         <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: tb/tb_dm_sbus_arbiter.sv
// Directed-vector bench for dm_sbus_arbiter (NumReq=2, BusWidth=32, MaxOutstanding=2).
module tb_dm_sbus_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        dmactive_i;
  logic [1:0]  req_i;
  logic [63:0] add_i;
  logic [1:0]  we_i;
  logic [63:0] wdata_i;
  logic [7:0]  be_i;
  logic [1:0]  gnt_o;
  logic [1:0]  r_valid_o;
  logic [31:0] r_rdata_o;
  logic        master_req_o;
  logic [31:0] master_add_o;
  logic        master_we_o;
  logic [31:0] master_wdata_o;
  logic [3:0]  master_be_o;
  logic        master_gnt_i;
  logic        master_r_valid_i;
  logic [31:0] master_r_rdata_i;
  logic        resp_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  dm_sbus_arbiter #(.NumReq(2), .BusWidth(32), .MaxOutstanding(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .dmactive_i(dmactive_i),
    .req_i(req_i), .add_i(add_i), .we_i(we_i), .wdata_i(wdata_i), .be_i(be_i),
    .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o),
    .master_req_o(master_req_o), .master_add_o(master_add_o), .master_we_o(master_we_o),
    .master_wdata_o(master_wdata_o), .master_be_o(master_be_o),
    .master_gnt_i(master_gnt_i), .master_r_valid_i(master_r_valid_i),
    .master_r_rdata_i(master_r_rdata_i), .resp_err_o(resp_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] r, input logic g, input logic v, input logic [31:0] d);
    req_i            = r;
    master_gnt_i     = g;
    master_r_valid_i = v;
    master_r_rdata_i = d;
  endtask

  task automatic cyc;
    @(posedge clk_i);
    #1;
  endtask

  logic [1:0]  exp_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [31:0] exp_add [4] = '{32'h1000, 32'h2000, 32'h1000, 32'h2000};
  logic [1:0]  exp_rv  [4] = '{2'b00, 2'b01, 2'b10, 2'b01};

  initial begin
    rst_ni     = 1'b0;
    dmactive_i = 1'b1;
    add_i      = {32'h2000, 32'h1000};
    wdata_i    = {32'hB1, 32'hA0};
    be_i       = {4'hC, 4'h3};
    we_i       = 2'b10;
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    #2;
    chk("rst_req", master_req_o, 0);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_rv", r_valid_o, 0);
    chk("rst_err", resp_err_o, 0);
    chk("rst_cnt", dut.cnt_q, 0);
    #10 rst_ni = 1'b1;

    // single requester
    cyc; drive(2'b01, 1'b1, 1'b0, 32'h0); #1;
    chk("single_gnt", gnt_o, 2'b01);
    chk("single_add", master_add_o, 32'h1000);
    chk("single_be", master_be_o, 4'h3);
    chk("single_wdata", master_wdata_o, 32'hA0);
    chk("single_we", master_we_o, 0);
    cyc; drive(2'b00, 1'b0, 1'b0, 32'h0); #1;
    chk("single_cnt1", dut.cnt_q, 1);
    cyc; drive(2'b00, 1'b0, 1'b1, 32'hCAFE); #1;
    chk("single_rv", r_valid_o, 2'b01);
    chk("single_rdata", r_rdata_o, 32'hCAFE);
    chk("single_err", resp_err_o, 0);
    cyc; drive(2'b00, 1'b0, 1'b0, 32'h0); #1;
    chk("single_cnt0", dut.cnt_q, 0);

    // lock: rr pointer now favours req1, so only the lock keeps req0 on the bus
    for (int i = 0; i < 3; i++) begin
      cyc; drive(2'b01, 1'b0, 1'b0, 32'h0); #1;
      chk("lock_add0", master_add_o, 32'h1000);
      chk("lock_gnt0", gnt_o, 0);
    end
    cyc; drive(2'b11, 1'b0, 1'b0, 32'h0); #1;
    chk("lock_hold_add", master_add_o, 32'h1000);
    chk("lock_hold_req", master_req_o, 1);
    cyc; drive(2'b11, 1'b1, 1'b0, 32'h0); #1;
    chk("lock_gnt_r0", gnt_o, 2'b01);
    chk("lock_gnt_add", master_add_o, 32'h1000);
    cyc; drive(2'b10, 1'b1, 1'b0, 32'h0); #1;
    chk("lock_next_r1", gnt_o, 2'b10);
    chk("lock_next_add", master_add_o, 32'h2000);
    chk("lock_next_we", master_we_o, 1);
    cyc; drive(2'b00, 1'b0, 1'b1, 32'h11); #1;
    chk("lock_rv0", r_valid_o, 2'b01);
    cyc; drive(2'b00, 1'b0, 1'b1, 32'h22); #1;
    chk("lock_rv1", r_valid_o, 2'b10);

    // contention with a response each cycle after the first grant
    for (int i = 0; i < 4; i++) begin
      cyc; drive(2'b11, 1'b1, (i > 0), 32'(i)); #1;
      chk("cont_gnt", gnt_o, exp_gnt[i]);
      chk("cont_add", master_add_o, exp_add[i]);
      chk("cont_rv", r_valid_o, exp_rv[i]);
    end
    chk("cont_cnt", dut.cnt_q, 1);
    cyc; drive(2'b00, 1'b0, 1'b1, 32'h0); #1;
    chk("cont_rv_last", r_valid_o, 2'b10);

    // outstanding limit
    cyc; drive(2'b01, 1'b1, 1'b0, 32'h0); #1;
    chk("full_g0", gnt_o, 2'b01);
    cyc; drive(2'b10, 1'b1, 1'b0, 32'h0); #1;
    chk("full_g1", gnt_o, 2'b10);
    cyc; drive(2'b11, 1'b1, 1'b0, 32'h0); #1;
    chk("full_req", master_req_o, 0);
    chk("full_gnt", gnt_o, 0);
    chk("full_add", master_add_o, 0);
    chk("full_cnt", dut.cnt_q, 2);
    cyc; drive(2'b11, 1'b0, 1'b1, 32'h77); #1;
    chk("full_rv_first", r_valid_o, 2'b01);
    chk("full_rdata", r_rdata_o, 32'h77);
    chk("full_req_still0", master_req_o, 0);
    cyc; drive(2'b11, 1'b1, 1'b1, 32'h88); #1;
    chk("full_rearm", master_req_o, 1);
    chk("full_gnt_same", gnt_o, 2'b01);
    chk("full_rv_same", r_valid_o, 2'b10);
    cyc; drive(2'b00, 1'b0, 1'b1, 32'h99); #1;
    chk("full_cnt_same", dut.cnt_q, 1);
    chk("full_rv_tail", r_valid_o, 2'b01);
    cyc; drive(2'b00, 1'b0, 1'b0, 32'h0); #1;
    chk("full_cnt0", dut.cnt_q, 0);

    // stray response
    cyc; drive(2'b00, 1'b0, 1'b1, 32'h55); #1;
    chk("stray_err", resp_err_o, 1);
    chk("stray_rv", r_valid_o, 0);
    cyc; drive(2'b00, 1'b0, 1'b0, 32'h0); #1;
    chk("stray_err_pulse", resp_err_o, 0);

    // dmactive drop while locked with one outstanding
    cyc; drive(2'b10, 1'b1, 1'b0, 32'h0); #1;
    chk("dm_g1", gnt_o, 2'b10);
    cyc; drive(2'b01, 1'b0, 1'b0, 32'h0); #1;
    chk("dm_lock_add", master_add_o, 32'h1000);
    cyc; dmactive_i = 1'b0; drive(2'b01, 1'b1, 1'b0, 32'h0); #1;
    chk("dm_req", master_req_o, 0);
    chk("dm_gnt", gnt_o, 0);
    cyc; drive(2'b00, 1'b0, 1'b1, 32'hBEEF); #1;
    chk("dm_unlock", dut.locked_q, 0);
    chk("dm_rv", r_valid_o, 2'b10);
    chk("dm_rdata", r_rdata_o, 32'hBEEF);
    cyc; dmactive_i = 1'b1; drive(2'b10, 1'b0, 1'b0, 32'h0); #1;
    chk("dm_resume_add", master_add_o, 32'h2000);
    cyc; drive(2'b10, 1'b1, 1'b0, 32'h0); #1;
    chk("dm_resume_gnt", gnt_o, 2'b10);

    // asynchronous reset mid-transfer
    cyc; drive(2'b11, 1'b0, 1'b0, 32'h0); #2;
    chk("pre_rst_cnt", dut.cnt_q, 1);
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    rst_ni = 1'b0; #1;
    chk("mid_rst_req", master_req_o, 0);
    chk("mid_rst_gnt", gnt_o, 0);
    chk("mid_rst_rv", r_valid_o, 0);
    chk("mid_rst_cnt", dut.cnt_q, 0);
    chk("mid_rst_lock", dut.locked_q, 0);
    #10 rst_ni = 1'b1;
    cyc; drive(2'b00, 1'b0, 1'b1, 32'h1); #1;
    chk("post_rst_err", resp_err_o, 1);
    chk("post_rst_rv", r_valid_o, 0);
    cyc; drive(2'b00, 1'b0, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
